qpp_deinterleaver: RTL and testbench
====================================

Name: qpp_deinterleaver

Overview:
- Receive end of the coder interleaver. Accepts the bit-serial interleaved stream c'(i) = c(pi(i)) for one block.
- Stores each bit at its natural position using the LTE QPP address pi(i) = (f1*i + f2*i^2) mod K.
- After a full block is captured, emits the restored natural-order block as bytes over a valid/ready handshake.
- Sits between the serial link (outpii) and the byte-wise consumer. It is also the loopback checker for the interleaver.

Parameters:
- KMAX, 6144, buffer depth in bits; the largest supported block.
- AW, 13, width of the bit address and bit counter (ceil(log2(KMAX))).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clear  input  1  asynchronous active-high reset.
- k_size_6144  input  1  block size select: 0 = K=1056 (f1=17, f2=66), 1 = K=6144 (f1=263, f2=480). Sampled only on start.
- start  input  1  single-cycle pulse that begins a block. Honoured only in IDLE.
- bit_in  input  1  serial interleaved data bit.
- bit_valid  input  1  bit_in is valid this cycle. Honoured only in FILL.
- byte_out  output  8  natural-order byte. Bit 7 holds the lowest bit index: byte j = {c(8j), ..., c(8j+7)}.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  consumer accepts byte_out. A transfer occurs when byte_valid & byte_ready.
- busy  output  1  high in FILL or DRAIN.
- done  output  1  one-cycle pulse after the last byte transfers.

Behaviour:
- Reset (clear=1, any time, including mid-block):
  - state = IDLE; byte_out = 0; byte_valid = 0; busy = 0; done = 0.
  - All counters reset to 0.
  - Buffer contents are not cleared and are don't-care.
- States: IDLE, FILL, DRAIN.
- IDLE, on start:
  - Latch k_size_6144 into k_sel; K, f1 and f2 come from k_sel.
  - i = 0; pi = 0; g = (f1+f2) mod K, i.e. 83 for K=1056 and 743 for K=6144.
  - Next state FILL; busy goes high the next cycle.
- FILL, on each bit_valid:
  - mem[pi] <= bit_in.
  - pi <= (pi + g) mod K; g <= (g + 2*f2) mod K; i <= i + 1.
  - Each mod is a single compare-and-subtract, because both operands are already < K. No multipliers.
- FILL, exit:
  - When bit_valid is accepted with i == K-1, go to DRAIN; byte counter j = 0.
  - No bit_valid means no state change; gaps of any length are allowed.
- DRAIN:
  - byte_valid is asserted no later than 2 cycles after the last bit is accepted.
  - byte_out = mem[8j .. 8j+7] and holds stable while byte_valid & !byte_ready.
  - On a transfer, j increments and the next byte is presented. Back-to-back transfers at 1 byte/cycle are supported when byte_ready stays high; a one-cycle bubble is permitted only for the first byte.
  - After byte K/8-1 (131 or 767) transfers: byte_valid = 0, done pulses for 1 cycle, state = IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - bit_valid in IDLE or DRAIN is ignored; no write occurs.
  - k_size_6144 changes after start have no effect.
- Simultaneous events: start is accepted in the same cycle that done is high, because the state is IDLE then.
- Width rules:
  - pi, g, i and j are AW bits.
  - 2*f2 is a constant: 132 or 960.
  - The intermediate pi+g is AW+1 bits before reduction.

Optional Feature:
- Macro: QPP_DEINT_BYPASS_EN.
- With the macro defined:
  - Adds input port bypass (1 bit), latched on start together with k_size_6144.
  - When the latched value is 1, the FILL write address is i instead of pi. The block then accepts the natural-order stream (outi) and simply packs it into bytes.
- Without the macro: the port is absent and the write address is always pi.

Decomposition:
- Shared package qpp_pkg holds:
  - K_1056 and K_6144 constants.
  - F1/F2 constants for both sizes.
  - G0 constants (83, 743).
  - Two-f2 step constants (132, 960).
  - The state enum {IDLE, FILL, DRAIN}.
- One sub-module, qpp_addr_gen, contains the recursive pi/g update with modular reduction. Inputs: clk, clear, init, step, k_sel. Output: pi.
- qpp_addr_gen is reusable by the interleaver-side index generator.

Test Plan:
- K=1056, start, 1056 bits with only i=1 equal to 1 (pi(1)=83) -> 132 bytes; byte 10 = 8'h10; all other bytes 8'h00; done pulses once.
- K=6144, only i=2 equal to 1 (pi(2)=2446) -> 768 bytes; byte 305 = 8'h02; all others 0. Check the pi sequence starts 0, 743, 2446.
- Round trip: random 6144-bit block through the coder interleaver model, serialized, then this block -> output bytes equal the original block; repeat for K=1056.
- Backpressure: byte_ready toggles randomly and bit_valid has random gaps -> byte_out stays stable while stalled; no bytes are lost or duplicated; byte count = K/8.
- clear asserted at bit 500 of FILL, then a new K=1056 start -> outputs zero immediately; the new block is restored correctly. start and bit_valid pulses during DRAIN are ignored.
- With QPP_DEINT_BYPASS_EN and bypass=1, K=1056, input bit i = i[0] -> every byte = 8'h55.

Source files
------------

// File: rtl/qpp_pkg.sv
// rtl/qpp_pkg.sv - shared constants and types for the QPP deinterleaver and address generator
//
// Holds the two supported LTE block sizes with their f1/f2 coefficients.
// G0 is the first increment of the recursive address, (f1+f2) mod K.
// TWO_F2 is the constant second difference, 2*f2.
// The FSM state encoding is shared with the interleaver-side logic.
package qpp_pkg;

   localparam int QPP_AW = 13;

   localparam logic [12:0] K_1056  = 13'd1056;
   localparam logic [12:0] K_6144  = 13'd6144;

   localparam logic [12:0] F1_1056 = 13'd17;
   localparam logic [12:0] F2_1056 = 13'd66;
   localparam logic [12:0] F1_6144 = 13'd263;
   localparam logic [12:0] F2_6144 = 13'd480;

   // f1+f2 is already below K for both sizes, so no reduction is needed here.
   localparam logic [12:0] G0_1056 = F1_1056 + F2_1056;   // 83
   localparam logic [12:0] G0_6144 = F1_6144 + F2_6144;   // 743

   localparam logic [12:0] TWO_F2_1056 = 13'(2 * F2_1056); // 132
   localparam logic [12:0] TWO_F2_6144 = 13'(2 * F2_6144); // 960

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } qpp_state_t;

endpackage

// File: rtl/qpp_deinterleaver_if.sv
// rtl/qpp_deinterleaver_if.sv - serial bit input and byte output handshake bundle
//
// Signals:
//   bit_in, bit_valid         serial interleaved stream into the deinterleaver
//   byte_out, byte_valid      natural-order bytes out of the deinterleaver
//   byte_ready                consumer accepts byte_out
// Modports:
//   master  the link/consumer side (drives bits, accepts bytes)
//   slave   the deinterleaver side
interface qpp_deinterleaver_if;

   logic       bit_in;
   logic       bit_valid;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       byte_ready;

   modport master (
      output bit_in,
      output bit_valid,
      output byte_ready,
      input  byte_out,
      input  byte_valid
   );

   modport slave (
      input  bit_in,
      input  bit_valid,
      input  byte_ready,
      output byte_out,
      output byte_valid
   );

endinterface

// File: rtl/qpp_addr_gen.sv
// rtl/qpp_addr_gen.sv - recursive LTE QPP address generator, pi(i) = (f1*i + f2*i^2) mod K
//
// Ports:
//   clk    system clock
//   clear  asynchronous active-high reset
//   init   load pi = 0 and g = (f1+f2) mod K for the selected size
//   step   advance to the next index: pi += g, g += 2*f2, both mod K
//   k_sel  size select, 0 = K 1056, 1 = K 6144 (must be stable when init/step)
//   pi     current address
//
// Both operands of every sum are already below K, so one conditional
// subtract is an exact mod; no multiplier is needed.
module qpp_addr_gen
   import qpp_pkg::*;
#(
   parameter int AW = QPP_AW
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          init,
   input  logic          step,
   input  logic          k_sel,
   output logic [AW-1:0] pi
);

   logic [AW-1:0] g;
   logic [AW-1:0] k_mod;
   logic [AW-1:0] g0;
   logic [AW-1:0] two_f2;
   logic [AW:0]   pi_sum;
   logic [AW:0]   g_sum;
   logic [AW-1:0] pi_next;
   logic [AW-1:0] g_next;

   always_comb begin
      k_mod  = k_sel ? AW'(K_6144)      : AW'(K_1056);
      g0     = k_sel ? AW'(G0_6144)     : AW'(G0_1056);
      two_f2 = k_sel ? AW'(TWO_F2_6144) : AW'(TWO_F2_1056);

      pi_sum = {1'b0, pi} + {1'b0, g};
      g_sum  = {1'b0, g}  + {1'b0, two_f2};

      if (pi_sum >= {1'b0, k_mod})
         pi_next = AW'(pi_sum - {1'b0, k_mod});
      else
         pi_next = pi_sum[AW-1:0];

      if (g_sum >= {1'b0, k_mod})
         g_next = AW'(g_sum - {1'b0, k_mod});
      else
         g_next = g_sum[AW-1:0];
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         pi <= '0;
         g  <= '0;
      end else if (init) begin
         pi <= '0;
         g  <= g0;
      end else if (step) begin
         pi <= pi_next;
         g  <= g_next;
      end
   end

endmodule

// File: rtl/qpp_deinterleaver.sv
// rtl/qpp_deinterleaver.sv - LTE QPP block deinterleaver: serial bits in, natural-order bytes out
//
// Ports:
//   clk          system clock
//   clear        asynchronous active-high reset
//   k_size_6144  block size select, sampled on start (0 = K 1056, 1 = K 6144)
//   start        begins a block; honoured only in IDLE
//   bypass       (only with QPP_DEINT_BYPASS_EN) sampled on start; when set the
//                stream is taken as natural order and written at address i
//   bus          slave side of qpp_deinterleaver_if (bit_in/bit_valid in,
//                byte_out/byte_valid/byte_ready out)
//   busy         high in FILL or DRAIN
//   done         one-cycle pulse after the last byte transfers
//
// Optional feature macro: QPP_DEINT_BYPASS_EN
//
// The bit buffer is split into 8 banks keyed by address[2:0] so one row read
// yields a whole byte while writes stay one bit wide.
module qpp_deinterleaver
   import qpp_pkg::*;
#(
   parameter int KMAX = 6144,
   parameter int AW   = QPP_AW
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 k_size_6144,
   input  logic                 start,
`ifdef QPP_DEINT_BYPASS_EN
   input  logic                 bypass,
`endif
   qpp_deinterleaver_if.slave   bus,
   output logic                 busy,
   output logic                 done
);

   localparam int NROW = KMAX / 8;
   localparam int RW   = AW - 3;

   qpp_state_t    state;
   logic          k_sel;
   logic [AW-1:0] i_cnt;
   logic [AW-1:0] j_cnt;
   logic [AW-1:0] k_cur;
   logic [AW-1:0] last_i;
   logic [AW-1:0] last_j;
   logic [AW-1:0] pi;
   logic [AW-1:0] waddr;
   logic [RW-1:0] rd_row;
   logic [7:0]    row_data;
   logic          accept_start;
   logic          accept_bit;
   logic          gen_k_sel;

   logic          mem [8][NROW];

`ifdef QPP_DEINT_BYPASS_EN
   logic          byp;
`endif

   always_comb begin
      k_cur        = k_sel ? AW'(K_6144) : AW'(K_1056);
      last_i       = k_cur - AW'(1);
      last_j       = (k_cur >> 3) - AW'(1);
      accept_start = (state == IDLE) && start;
      accept_bit   = (state == FILL) && bus.bit_valid;
      // The generator needs the new size in the same cycle it is initialised,
      // before k_sel has been latched.
      gen_k_sel    = accept_start ? k_size_6144 : k_sel;
   end

   qpp_addr_gen #(
      .AW (AW)
   ) u_addr (
      .clk   (clk),
      .clear (clear),
      .init  (accept_start),
      .step  (accept_bit),
      .k_sel (gen_k_sel),
      .pi    (pi)
   );

`ifdef QPP_DEINT_BYPASS_EN
   always_comb waddr = byp ? i_cnt : pi;
`else
   always_comb waddr = pi;
`endif

   // The first byte of a drain is loaded while byte_valid is still low; after
   // that each transfer loads the row following the one being accepted.
   always_comb begin
      rd_row = bus.byte_valid ? RW'(j_cnt + AW'(1)) : '0;
      for (int b = 0; b < 8; b++)
         row_data[7-b] = mem[b][rd_row];
   end

   // Buffer contents survive clear; they are fully rewritten by every block.
   always_ff @(posedge clk) begin
      if (accept_bit)
         mem[waddr[2:0]][waddr[AW-1:3]] <= bus.bit_in;
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state          <= IDLE;
         k_sel          <= 1'b0;
         i_cnt          <= '0;
         j_cnt          <= '0;
         bus.byte_out   <= '0;
         bus.byte_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef QPP_DEINT_BYPASS_EN
         byp            <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  k_sel <= k_size_6144;
`ifdef QPP_DEINT_BYPASS_EN
                  byp   <= bypass;
`endif
                  i_cnt <= '0;
                  busy  <= 1'b1;
                  state <= FILL;
               end
            end

            FILL: begin
               if (bus.bit_valid) begin
                  i_cnt <= i_cnt + AW'(1);
                  if (i_cnt == last_i) begin
                     j_cnt <= '0;
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (!bus.byte_valid) begin
                  bus.byte_out   <= row_data;
                  bus.byte_valid <= 1'b1;
               end else if (bus.byte_ready) begin
                  if (j_cnt == last_j) begin
                     bus.byte_valid <= 1'b0;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     j_cnt        <= j_cnt + AW'(1);
                     bus.byte_out <= row_data;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// tb/tb_qpp_deinterleaver.sv - randomized self-checking bench for qpp_deinterleaver
module tb_qpp_deinterleaver;

   logic clk;
   logic clear;
   logic k_size_6144;
   logic start;
   logic busy;
   logic done;
`ifdef QPP_DEINT_BYPASS_EN
   logic bypass;
`endif

   qpp_deinterleaver_if bus_if ();

   qpp_deinterleaver dut (
      .clk         (clk),
      .clear       (clear),
      .k_size_6144 (k_size_6144),
      .start       (start),
`ifdef QPP_DEINT_BYPASS_EN
      .bypass      (bypass),
`endif
      .bus         (bus_if.slave),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   bit         s_bits [6144];   // serial stream as sent on the link
   bit         c_bits [6144];   // natural-order block
   logic [7:0] exp_bytes [768];
   logic [7:0] rx_bytes [768];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int qpp_pi(input int k, input int i);
      longint f1, f2, li;
      f1 = (k == 6144) ? 263 : 17;
      f2 = (k == 6144) ? 480 : 66;
      li = i;
      return int'((f1 * li + f2 * li * li) % longint'(k));
   endfunction

   function automatic int k_of(input bit k6144);
      return k6144 ? 6144 : 1056;
   endfunction

   // Natural block from the stream: the link carries c'(i) = c(pi(i)).
   task automatic model_from_stream(input int k, input bit natural);
      for (int i = 0; i < k; i++) begin
         if (natural) c_bits[i] = s_bits[i];
         else         c_bits[qpp_pi(k, i)] = s_bits[i];
      end
      for (int j = 0; j < k / 8; j++)
         for (int b = 0; b < 8; b++)
            exp_bytes[j][7-b] = c_bits[8*j + b];
   endtask

   // Coder-side interleaver: pick a random natural block and serialise it.
   task automatic make_roundtrip(input int k);
      for (int n = 0; n < k; n++) c_bits[n] = 1'($urandom);
      for (int i = 0; i < k; i++) s_bits[i] = c_bits[qpp_pi(k, i)];
      for (int j = 0; j < k / 8; j++)
         for (int b = 0; b < 8; b++)
            exp_bytes[j][7-b] = c_bits[8*j + b];
   endtask

   task automatic do_start(input bit k6144, input bit byp);
`ifdef QPP_DEINT_BYPASS_EN
      bypass = byp;
`else
      if (byp) check("bypass_unsupported", 32'd1, 32'd0);
`endif
      k_size_6144 = k6144;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      k_size_6144 = ~k6144;   // later changes must not matter
`ifdef QPP_DEINT_BYPASS_EN
      bypass      = ~byp;
`endif
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic send_bits(input int k, input int nbits, input bit gaps, input bit pi_chk);
      for (int i = 0; i < nbits; i++) begin
         if (gaps) begin
            int g;
            g = (($urandom & 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            bus_if.bit_valid = 1'b0;
            repeat (g) @(negedge clk);
         end
         bus_if.bit_valid = 1'b1;
         bus_if.bit_in    = s_bits[i];
         if (pi_chk && i < 3)
            check($sformatf("pi_%0d", i), 32'(dut.u_addr.pi), 32'(qpp_pi(k, i)));
         @(negedge clk);
      end
      bus_if.bit_valid = 1'b0;
   endtask

   task automatic drain(input int k, input bit bp, input bit noise, input string tag);
      int   nbytes, got, cyc, done_cnt, first_wait;
      bit   hold_pending;
      logic [7:0] held;
      nbytes = k / 8; got = 0; cyc = 0; done_cnt = 0; first_wait = 0;
      hold_pending = 0; held = '0;
      while (got < nbytes && cyc < 40000) begin
         if (done) done_cnt++;
         if (hold_pending && bus_if.byte_valid)
            check({tag, "_hold"}, bus_if.byte_out, held);
         if (!bp && got > 0)
            check({tag, "_b2b"}, bus_if.byte_valid, 1'b1);
         if (got == 0 && !bus_if.byte_valid) first_wait++;
         bus_if.byte_ready = bp ? 1'($urandom) : 1'b1;
         if (noise) begin
            start            = 1'($urandom);
            bus_if.bit_valid = 1'($urandom);
            bus_if.bit_in    = 1'($urandom);
            k_size_6144      = 1'($urandom);
         end
         if (bus_if.byte_valid && bus_if.byte_ready) begin
            if (got == 0 && !bp) check({tag, "_first_lat"}, 32'(first_wait <= 2), 32'd1);
            rx_bytes[got] = bus_if.byte_out;
            check($sformatf("%s_byte%0d", tag, got), bus_if.byte_out, exp_bytes[got]);
            got++;
            hold_pending = 0;
         end else if (bus_if.byte_valid) begin
            hold_pending = 1;
            held         = bus_if.byte_out;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; bus_if.bit_valid = 1'b0;
      check({tag, "_count"}, got, nbytes);
      repeat (3) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      bus_if.byte_ready = 1'b0;
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_valid"}, bus_if.byte_valid, 1'b0);
   endtask

   task automatic run_block(input bit k6144, input bit bp, input bit gaps, input bit noise,
                            input bit pi_chk, input bit byp, input string tag);
      int k;
      k = k_of(k6144);
      do_start(k6144, byp);
      send_bits(k, k, gaps, pi_chk);
      drain(k, bp, noise, tag);
   endtask

   initial begin
      clear = 1'b1; k_size_6144 = 1'b0; start = 1'b0;
      bus_if.bit_in = 1'b0; bus_if.bit_valid = 1'b0; bus_if.byte_ready = 1'b0;
`ifdef QPP_DEINT_BYPASS_EN
      bypass = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_valid", bus_if.byte_valid, 1'b0);
      check("rst_byte", bus_if.byte_out, 8'h00);
      clear = 1'b0;
      @(negedge clk);

      // Single set bit at i=1, K=1056: c(83)=1.
      for (int i = 0; i < 6144; i++) s_bits[i] = 1'b0;
      s_bits[1] = 1'b1;
      model_from_stream(1056, 1'b0);
      run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "k1056_one");
      check("k1056_byte10", rx_bytes[10], 8'h10);
      check("k1056_byte0", rx_bytes[0], 8'h00);
      check("k1056_byte131", rx_bytes[131], 8'h00);

      // Single set bit at i=2, K=6144: c(2446)=1.
      for (int i = 0; i < 6144; i++) s_bits[i] = 1'b0;
      s_bits[2] = 1'b1;
      model_from_stream(6144, 1'b0);
      run_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "k6144_one");
      check("k6144_byte305", rx_bytes[305], 8'h02);
      check("k6144_byte767", rx_bytes[767], 8'h00);

      // Round trips, then with backpressure and input gaps.
      make_roundtrip(6144);
      run_block(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rt6144");
      make_roundtrip(1056);
      run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rt1056");
      make_roundtrip(1056);
      run_block(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "bp1056");
      make_roundtrip(6144);
      run_block(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "bp6144");

      // Abort mid-fill with clear, then a fresh block with noise during drain.
      make_roundtrip(1056);
      do_start(1'b0, 1'b0);
      send_bits(1056, 500, 1'b0, 1'b0);
      clear = 1'b1;
      #1;
      check("clr_busy", busy, 1'b0);
      check("clr_valid", bus_if.byte_valid, 1'b0);
      check("clr_byte", bus_if.byte_out, 8'h00);
      check("clr_done", done, 1'b0);
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      make_roundtrip(1056);
      run_block(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "after_clr");

`ifdef QPP_DEINT_BYPASS_EN
      for (int i = 0; i < 1056; i++) s_bits[i] = 1'(i & 1);
      for (int j = 0; j < 132; j++) exp_bytes[j] = 8'h55;
      run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bypass");
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
